// File: rtl/tl_a_pkg.sv
// TileLink A-channel field widths, opcodes, beat structs and burst-length math.
// Shared by the burst queue and its FIFO.
package tl_a_pkg;

    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 3;
    localparam int SIZE_W   = 4;
    localparam int SOURCE_W = 2;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int CNT_W    = 12;

    localparam logic [OPCODE_W-1:0] PUT_FULL    = 3'd0;
    localparam logic [OPCODE_W-1:0] PUT_PARTIAL = 3'd1;
    localparam logic [OPCODE_W-1:0] ARITH       = 3'd2;
    localparam logic [OPCODE_W-1:0] LOGIC       = 3'd3;
    localparam logic [OPCODE_W-1:0] GET         = 3'd4;
    localparam logic [OPCODE_W-1:0] HINT        = 3'd5;
    localparam logic [OPCODE_W-1:0] ACQ_BLOCK   = 3'd6;
    localparam logic [OPCODE_W-1:0] ACQ_PERM    = 3'd7;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
    } tl_a_hdr_t;

    typedef struct packed {
        tl_a_hdr_t           hdr;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_a_beat_t;

    // Returns beats-1 so the 4096-beat maximum still fits the 12-bit counters.
    function automatic logic [CNT_W-1:0] beats_m1(input logic [OPCODE_W-1:0] opcode,
                                                  input logic [SIZE_W-1:0]   size,
                                                  input logic [SIZE_W-1:0]   beat_lg);
        logic [CNT_W-1:0] one;
        one = CNT_W'(1);
        if (!opcode[2] && (size > beat_lg))
            beats_m1 = (one << (size - beat_lg)) - one;
        else
            beats_m1 = '0;
    endfunction

endpackage

// File: rtl/tl_a_fifo.sv
// Generic registered circular FIFO; write-to-read latency one cycle, no bypass.
// in_rdy_o depends only on occupancy, so a full FIFO refuses input even while draining.
module tl_a_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_vld_i,
    output logic                       in_rdy_o,
    input  logic [W-1:0]               in_dat_i,
    output logic                       out_vld_o,
    input  logic                       out_rdy_i,
    output logic [W-1:0]               out_dat_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign in_rdy_o  = (count_q != CW'(DEPTH));
    assign out_vld_o = (count_q != '0);
    assign out_dat_o = mem_q[rptr_q];
    assign count_o   = count_q;
    assign push      = in_vld_i && in_rdy_o;
    assign pop       = out_vld_o && out_rdy_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= in_dat_i;
    end

endmodule

// File: rtl/tl_a_burst_queue.sv
// Buffers the arbitrated TL-A stream, marks first/last beats and flags mid-burst header changes.
// Latency one cycle through the FIFO; io_in_ready drops only when full.
module tl_a_burst_queue
    import tl_a_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int BEAT_BYTES_LOG2 = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    io_in_ready,
    input  logic                    io_in_valid,
    input  logic [OPCODE_W-1:0]     io_in_bits_opcode,
    input  logic [PARAM_W-1:0]      io_in_bits_param,
    input  logic [SIZE_W-1:0]       io_in_bits_size,
    input  logic [SOURCE_W-1:0]     io_in_bits_source,
    input  logic [ADDR_W-1:0]       io_in_bits_address,
    input  logic [DATA_W-1:0]       io_in_bits_data,
    input  logic                    io_in_bits_corrupt,
    input  logic                    io_out_ready,
    output logic                    io_out_valid,
    output logic [OPCODE_W-1:0]     io_out_bits_opcode,
    output logic [PARAM_W-1:0]      io_out_bits_param,
    output logic [SIZE_W-1:0]       io_out_bits_size,
    output logic [SOURCE_W-1:0]     io_out_bits_source,
    output logic [ADDR_W-1:0]       io_out_bits_address,
    output logic [DATA_W-1:0]       io_out_bits_data,
    output logic                    io_out_bits_corrupt,
    output logic                    io_out_first,
    output logic                    io_out_last,
    output logic [$clog2(DEPTH):0]  io_count,
    output logic                    io_protocol_err
);
    localparam logic [SIZE_W-1:0] BEAT_LG = SIZE_W'(BEAT_BYTES_LOG2);

    tl_a_beat_t       in_beat, head;
    tl_a_hdr_t        hdr_q, hdr_d;
    logic [CNT_W-1:0] out_rem_q, out_rem_d, in_rem_q, in_rem_d;
    logic [CNT_W-1:0] head_m1, in_m1;
    logic             err_q, err_d;
    logic             in_fire, out_fire;

    assign in_beat.hdr.opcode  = io_in_bits_opcode;
    assign in_beat.hdr.param   = io_in_bits_param;
    assign in_beat.hdr.size    = io_in_bits_size;
    assign in_beat.hdr.source  = io_in_bits_source;
    assign in_beat.hdr.address = io_in_bits_address;
    assign in_beat.data        = io_in_bits_data;
    assign in_beat.corrupt     = io_in_bits_corrupt;

    tl_a_fifo #(.W($bits(tl_a_beat_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (clock),
        .rst_i     (reset),
        .in_vld_i  (io_in_valid),
        .in_rdy_o  (io_in_ready),
        .in_dat_i  (in_beat),
        .out_vld_o (io_out_valid),
        .out_rdy_i (io_out_ready),
        .out_dat_o (head),
        .count_o   (io_count)
    );

    assign io_out_bits_opcode  = head.hdr.opcode;
    assign io_out_bits_param   = head.hdr.param;
    assign io_out_bits_size    = head.hdr.size;
    assign io_out_bits_source  = head.hdr.source;
    assign io_out_bits_address = head.hdr.address;
    assign io_out_bits_data    = head.data;
    assign io_out_bits_corrupt = head.corrupt;

    assign in_fire  = io_in_valid && io_in_ready;
    assign out_fire = io_out_valid && io_out_ready;
    assign head_m1  = beats_m1(head.hdr.opcode, head.hdr.size, BEAT_LG);
    assign in_m1    = beats_m1(io_in_bits_opcode, io_in_bits_size, BEAT_LG);

    // An empty queue reports a lone beat so stale storage never leaks into the markers.
    assign io_out_first    = (out_rem_q == '0);
    assign io_out_last     = (out_rem_q == CNT_W'(1)) ||
                             ((out_rem_q == '0) && ((head_m1 == '0) || !io_out_valid));
    assign io_protocol_err = err_q;

    always_comb begin
        out_rem_d = out_rem_q;
        in_rem_d  = in_rem_q;
        hdr_d     = hdr_q;
        err_d     = err_q;
        if (out_fire)
            out_rem_d = (out_rem_q == '0) ? head_m1 : out_rem_q - CNT_W'(1);
        if (in_fire) begin
            if (in_rem_q == '0) begin
                hdr_d    = in_beat.hdr;
                in_rem_d = in_m1;
            end else begin
                if (in_beat.hdr != hdr_q) err_d = 1'b1;
                in_rem_d = in_rem_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_rem_q <= '0;
            in_rem_q  <= '0;
            hdr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            out_rem_q <= out_rem_d;
            in_rem_q  <= in_rem_d;
            hdr_q     <= hdr_d;
            err_q     <= err_d;
        end
    end

endmodule
